// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the controller state encoding, the default operand width and
// a helper that sizes the bit counter for any operand width.
package serial_subtractor_pkg;

    // Operand width used when the parent does not override it.
    localparam int DEFAULT_WIDTH = 4;

    // Controller states: waiting for work, walking the bits, presenting a result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The bit counter must index bits 0..width-1. A single-bit operand still
    // needs a one-bit counter so that the vector is never zero-width.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
// Purely combinational, zero latency.
// No flow control; the parent decides when the result is consumed.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit is the parity of the three inputs.
    assign d = a ^ b ^ bin;

    // Borrow when b exceeds a, or when they match and a borrow arrives.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in, one bit per clock, LSB first.
// Latency: start accepted at edge k, result and done pulse after edge k+WIDTH.
// No backpressure: start is only honoured in IDLE and ignored otherwise.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam int             MSB  = WIDTH - 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;

    // Operands captured at start; they are indexed, never shifted, so the
    // sign bits stay available for the overflow decision on the last bit.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             br_q;
    logic [CW-1:0]    cnt;

    // Private accumulator for difference bits; the visible diff port only
    // changes once the whole word is known.
    logic [WIDTH-1:0] d_acc;
    logic [WIDTH-1:0] d_full;

    logic             bit_a;
    logic             bit_b;
    logic             bit_d;
    logic             bit_bout;
    logic             last_bit;

    assign bit_a    = a_q[cnt];
    assign bit_b    = b_q[cnt];
    assign last_bit = (cnt == LAST);

    // The single shared bit slice, fed a new bit pair every SHIFT cycle.
    full_subtractor u_fs (
        .a    (bit_a),
        .b    (bit_b),
        .bin  (br_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Accumulated difference with the current bit merged in.
    always_comb begin
        d_full      = d_acc;
        d_full[cnt] = bit_d;
    end

    // State register; reset wins over everything, including an in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and status outputs, both derived from the state alone.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial datapath and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            br_q  <= 1'b0;
            cnt   <= '0;
            d_acc <= '0;
            diff  <= '0;
            b_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        br_q  <= b_in;
                        cnt   <= '0;
                        d_acc <= '0;
                    end
                end
                SHIFT: begin
                    d_acc <= d_full;
                    br_q  <= bit_bout;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        cnt   <= '0;
                        diff  <= d_full;
                        b_out <= bit_bout;
                        // Overflow only when operand signs differ and the
                        // result sign departs from the minuend sign.
                        ovf   <= (a_q[MSB] != b_q[MSB]) && (bit_d != a_q[MSB]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operations,
// expected results queued at issue time and checked when done pulses.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic [W-1:0] diff;
    logic         b_out;
    logic         ovf;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           mon_en = 1'b0;
    logic [W-1:0] held_diff = '0;
    logic         held_bout = 1'b0;
    logic         held_ovf = 1'b0;

    // Edge counter: after edge p it reads p.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] d, input logic bo, input logic ov);
        exp_t e;
        e.diff = d;
        e.bout = bo;
        e.ovf  = ov;
        e.cyc  = 0;
        return e;
    endfunction

    // Reference: plain integer arithmetic, unsigned for borrow, signed for overflow.
    function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
        exp_t e;
        int   ua;
        int   ub;
        int   r;
        int   sa;
        int   sb;
        int   s;
        ua = int'(ai);
        ub = int'(bi);
        r  = ua - ub - int'(ci);
        e.diff = r[W-1:0];
        e.bout = (r < 0);
        sa = ai[W-1] ? ua - (1 << W) : ua;
        sb = bi[W-1] ? ub - (1 << W) : ub;
        s  = sa - sb - int'(ci);
        e.ovf = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
        e.cyc = 0;
        return e;
    endfunction

    // Issue one operation; entered and left at posedge+1 with the DUT idle.
    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                         input bit perturb, input exp_t e);
        int n;
        a = ai;
        b = bi;
        b_in = ci;
        start = 1'b1;
        e.cyc = cyc + 1 + W;
        sb_q.push_back(e);
        @(posedge clk); #1;
        if (!perturb) start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        b_in = 1'($urandom);
        n = 0;
        while (!done && n < 3 * W) begin
            if (perturb) begin
                a = W'($urandom);
                b = W'($urandom);
                b_in = 1'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", done, 1);
        // A start still held here lands on the DONE edge and must be ignored.
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Start an operation, then reset it at edge k+2.
    task automatic abort_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
        a = ai;
        b = bi;
        b_in = ci;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        held_diff = '0;
        held_bout = 1'b0;
        held_ovf  = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_bout", b_out, 0);
        chk("abort_ovf", ovf, 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: pops on every done pulse, otherwise checks outputs hold.
    initial begin
        int   busy_run;
        exp_t e;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (done) begin
                    if (sb_q.size() == 0) begin
                        chk("spurious_done", done, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("diff", diff, e.diff);
                        chk("b_out", b_out, e.bout);
                        chk("ovf", ovf, e.ovf);
                        chk("latency", cyc, e.cyc);
                        chk("busy_len", busy_run, W);
                        chk("busy_in_done", busy, 0);
                        held_diff = e.diff;
                        held_bout = e.bout;
                        held_ovf  = e.ovf;
                    end
                    busy_run = 0;
                end else begin
                    chk("hold_diff", diff, held_diff);
                    chk("hold_bout", b_out, held_bout);
                    chk("hold_ovf", ovf, held_ovf);
                    busy_run = busy ? busy_run + 1 : 0;
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        rst = 1'b1;
        start = 1'b1;
        a = '1;
        b = '1;
        b_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_diff", diff, 0);
        chk("rst_bout", b_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        start = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        do_op(4'b0110, 4'b1100, 1'b0, 1'b0, mk(4'b1010, 1'b1, 1'b1));
        do_op(4'b1110, 4'b1000, 1'b0, 1'b0, mk(4'b0110, 1'b0, 1'b0));
        do_op(4'b0111, 4'b1110, 1'b0, 1'b0, mk(4'b1001, 1'b1, 1'b1));
        do_op(4'b0010, 4'b1001, 1'b0, 1'b0, mk(4'b1001, 1'b1, 1'b1));
        do_op(4'b0000, 4'b0000, 1'b1, 1'b0, mk(4'b1111, 1'b1, 1'b0));
        do_op(4'b0011, 4'b0101, 1'b0, 1'b1, mk(4'b1110, 1'b1, 1'b0));
        abort_op(4'b1010, 4'b0101, 1'b1);
        do_op(4'b0101, 4'b0011, 1'b1, 1'b0, mk(4'b0001, 1'b0, 1'b0));

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            do_op(ra, rb, rc, 1'($urandom), model(ra, rb, rc));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
